// File: rtl/comp_sweep_checker.sv
// rtl/comp_sweep_checker.sv - exhaustive sweep driver and golden-model checker for the W-bit comparator
// Optional: COMP_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module comp_sweep_checker #(
    parameter int W   = 2,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    input  logic [1:0]     o_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_cnt,
    output logic           first_err_valid,
    output logic [W-1:0]   first_err_a,
    output logic [W-1:0]   first_err_b
);

    localparam int HW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LAT);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state;
    state_t         state_next;
    logic [HW-1:0]  hold;
    logic [1:0]     expected;
    logic           sample;
    logic           mismatch;
    logic           last_pair;
    logic           stop_now;
    logic [2*W:0]   err_cnt_next;

    always_comb begin
        expected = 2'b00;
        if (a_out > b_out)
            expected = 2'b10;
        else if (a_out < b_out)
            expected = 2'b01;
    end

    assign sample    = (state == RUN) && (hold == HOLD_MAX);
    assign mismatch  = sample && (o_in != expected);
    assign last_pair = &{a_out, b_out};

`ifdef COMP_SWEEP_STOP_ON_ERR_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // Saturating count, including the check happening on this edge
    always_comb begin
        err_cnt_next = err_cnt;
        if (mismatch && !(&err_cnt))
            err_cnt_next = err_cnt + {{(2*W){1'b0}}, 1'b1};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && (last_pair || stop_now)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out           <= '0;
            b_out           <= '0;
            hold            <= '0;
            err_cnt         <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_out           <= '0;
                        b_out           <= '0;
                        hold            <= '0;
                        err_cnt         <= '0;
                        pass            <= 1'b0;
                        first_err_valid <= 1'b0;
                        first_err_a     <= '0;
                        first_err_b     <= '0;
                    end
                end
                RUN: begin
                    err_cnt <= err_cnt_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_a     <= a_out;
                        first_err_b     <= b_out;
                    end
                    if (sample) begin
                        hold <= '0;
                        // b is the inner loop; the final (or failing, when stopping) pair stays on the bus
                        if (!last_pair && !stop_now) begin
                            if (&b_out) begin
                                b_out <= '0;
                                a_out <= a_out + W'(1);
                            end else begin
                                b_out <= b_out + W'(1);
                            end
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                    if (state_next == FIN)
                        pass <= (err_cnt_next == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_sweep_checker.sv
// tb/tb_comp_sweep_checker.sv - directed bench for comp_sweep_checker with behavioural comparator models
module tb_comp_sweep_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start2;
    int         mode;

    logic [1:0] a1, b1, o1;
    logic       busy1, done1, pass1, fev1;
    logic [4:0] err1;
    logic [1:0] fea1, feb1;

    logic [1:0] a2, b2, o2;
    logic       busy2, done2, pass2, fev2;
    logic [4:0] err2;
    logic [1:0] fea2, feb2;
    int         cnt2;

    int n_cmp = 0;
    int n_err = 0;

    comp_sweep_checker #(.W(2), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a1), .b_out(b1), .o_in(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fev1), .first_err_a(fea1), .first_err_b(feb1)
    );

    comp_sweep_checker #(.W(2), .LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_out(a2), .b_out(b2), .o_in(o2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_valid(fev2), .first_err_a(fea2), .first_err_b(feb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ideal(input logic [1:0] a, input logic [1:0] b);
        if (a > b) return 2'b10;
        if (a < b) return 2'b01;
        return 2'b00;
    endfunction

    // mode 0 ideal, 1 stuck at 00, 2 wrong only for (2,1)
    assign o1 = (mode == 1) ? 2'b00 :
                (mode == 2 && a1 == 2'd2 && b1 == 2'd1) ? 2'b01 : ideal(a1, b1);

    // Cycle index within the LAT=3 sweep; result is only valid on the 4th cycle of each pair
    always @(posedge clk) begin
        if (!busy2) cnt2 <= 0;
        else        cnt2 <= cnt2 + 1;
    end
    assign o2 = (busy2 && (cnt2 % 4 == 3)) ? ideal(a2, b2) : 2'b11;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at the negedge of the first RUN cycle; returns at the negedge where done is high
    task automatic wait_done(input int pulse_at, output int bcnt, output int got, output int order_ok);
        int pidx;
        bcnt = 0; got = 0; order_ok = 1;
        for (int c = 0; c < 400; c++) begin
            if (pulse_at >= 0 && c == pulse_at) start = 1'b1;
            if (pulse_at >= 0 && c == pulse_at + 1) start = 1'b0;
            if (done1) begin
                got = 1;
                break;
            end
            if (busy1) begin
                pidx = bcnt / 2;
                if (a1 != 2'(pidx / 4) || b1 != 2'(pidx % 4)) order_ok = 0;
                bcnt++;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int mode;
        int pass;
        int err;
        int fev;
        int fea;
        int feb;
        int busy;
        int fa;
        int fb;
    } vec_t;

    vec_t tv[3];
    int bc, got, ord, dcnt;

    initial begin
        tv[0] = '{0, 1, 0,  0, 0, 0, 32, 3, 3};
`ifdef COMP_SWEEP_STOP_ON_ERR_EN
        tv[1] = '{1, 0, 1,  1, 0, 1, 4,  0, 1};
        tv[2] = '{2, 0, 1,  1, 2, 1, 20, 2, 1};
`else
        tv[1] = '{1, 0, 12, 1, 0, 1, 32, 3, 3};
        tv[2] = '{2, 0, 1,  1, 2, 1, 32, 3, 3};
`endif

        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({busy1, done1, pass1, err1, fev1, fea1, feb1, a1, b1}), 0);
        check("reset_outputs_lat3", int'({busy2, done2, pass2, err2, fev2}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy1, 0);

        for (int i = 0; i < 3; i++) begin
            mode = tv[i].mode;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(-1, bc, got, ord);
            check($sformatf("v%0d_done_seen", i), got, 1);
            check($sformatf("v%0d_busy_cycles", i), bc, tv[i].busy);
            check($sformatf("v%0d_pair_order", i), ord, 1);
            check($sformatf("v%0d_busy_in_fin", i), busy1, 0);
            check($sformatf("v%0d_pass", i), pass1, tv[i].pass);
            check($sformatf("v%0d_err_cnt", i), err1, tv[i].err);
            check($sformatf("v%0d_fe_valid", i), fev1, tv[i].fev);
            check($sformatf("v%0d_fe_a", i), fea1, tv[i].fea);
            check($sformatf("v%0d_fe_b", i), feb1, tv[i].feb);
            check($sformatf("v%0d_a_out", i), a1, tv[i].fa);
            check($sformatf("v%0d_b_out", i), b1, tv[i].fb);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), done1, 0);
            check($sformatf("v%0d_pass_held", i), pass1, tv[i].pass);
            check($sformatf("v%0d_err_held", i), err1, tv[i].err);
        end

        // Reset on cycle 10 of a sweep that has already logged errors
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", busy1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", int'({busy1, done1, pass1, err1, fev1, fea1, feb1, a1, b1}), 0);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done1 || busy1) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", dcnt, 0);
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1, bc, got, ord);
        check("after_abort_done", got, 1);
        check("after_abort_busy", bc, 32);
        check("after_abort_pass", pass1, 1);
        @(negedge clk);

        // start pulsed while busy must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, bc, got, ord);
        check("busy_start_done", got, 1);
        check("busy_start_cycles", bc, 32);
        @(negedge clk);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (done1 || busy1) dcnt++;
            @(negedge clk);
        end
        check("busy_start_no_restart", dcnt, 0);

        // start held across two sweeps
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        wait_done(-1, bc, got, ord);
        check("held1_done", got, 1);
        check("held1_busy", bc, tv[1].busy);
        check("held1_err", err1, tv[1].err);
        mode = 0;
        @(negedge clk);
        check("held_idle_gap", int'({busy1, done1}), 0);
        @(negedge clk);
        check("held2_busy_start", busy1, 1);
        check("held2_err_cleared", err1, 0);
        wait_done(-1, bc, got, ord);
        start = 1'b0;
        check("held2_done", got, 1);
        check("held2_busy", bc, 32);
        check("held2_order", ord, 1);
        check("held2_pass", pass1, 1);
        @(negedge clk);
        check("held2_done_one_cycle", done1, 0);

        // LAT=3 instance with garbage on every non-sample cycle
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bc = 0; got = 0;
        for (int c = 0; c < 400; c++) begin
            if (done2) begin
                got = 1;
                break;
            end
            if (busy2) bc++;
            @(negedge clk);
        end
        check("lat3_done", got, 1);
        check("lat3_busy", bc, 64);
        check("lat3_pass", pass2, 1);
        check("lat3_err", err2, 0);
        check("lat3_fe_valid", fev2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
